// File: rtl/i2c_reg_bank_pkg.sv
// Shared constants for the I2C register bank: address map, FLAGS bit positions
// and the default ID byte.
package i2c_reg_pkg;

    localparam logic [7:0] ADDR_ID       = 8'h00;
    localparam logic [7:0] ADDR_CTRL     = 8'h01;
    localparam logic [7:0] ADDR_STATUS   = 8'h02;
    localparam logic [7:0] ADDR_CMD      = 8'h03;
    localparam logic [7:0] ADDR_FLAGS    = 8'h04;
    localparam logic [7:0] ADDR_SCRATCH0 = 8'h05;

    localparam int FLAG_OVF   = 0;
    localparam int FLAG_EMPTY = 1;
    localparam int FLAG_FULL  = 2;
    localparam int FLAG_IRQ   = 7;

    localparam logic [7:0] ID_DEFAULT = 8'hA5;

endpackage

// File: rtl/i2c_reg_bank_if.sv
// Register-access bus between the SCL-domain i2c_slave (master side) and the
// clk-domain register bank (slave side).
interface i2c_reg_bank_if;

    logic       i2c_wr;
    logic [7:0] i2c_addr;
    logic [7:0] i2c_wdata;
    logic [7:0] i2c_rdata;

    modport master (output i2c_wr, output i2c_addr, output i2c_wdata, input i2c_rdata);
    modport slave  (input i2c_wr, input i2c_addr, input i2c_wdata, output i2c_rdata);

endinterface

// File: rtl/i2c_reg_bank_cmd_fifo.sv
// Synchronous first-word-fall-through command FIFO; a push into a full FIFO is
// only accepted when a pop frees the head slot in the same cycle.
module cmd_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [W-1:0]               din,
    input  logic                       pop,
    output logic [W-1:0]               dout,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       overflow_pulse
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

    logic [AW-1:0] wr_q, rd_q;
    logic [AW:0]   cnt_q;
    logic [W-1:0]  mem_q [DEPTH];
    logic          pop_ok, push_ok;

    assign full           = (cnt_q == DEPTH_C);
    assign empty          = (cnt_q == '0);
    assign count          = cnt_q;
    assign pop_ok         = pop & ~empty;
    assign push_ok        = push & (~full | pop_ok);
    assign overflow_pulse = push & full & ~pop_ok;
    // Gate the head so the output reads zero while empty, including after reset
    assign dout           = empty ? '0 : mem_q[rd_q];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (push_ok) wr_q <= wr_q + 1'b1;
            if (pop_ok)  rd_q <= rd_q + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_q] <= din;
    end

endmodule

// File: rtl/i2c_reg_bank.sv
// clk-domain register bank behind the SCL-clocked i2c_slave, with a command FIFO.
// Optional interrupt output enabled by defining I2C_REG_BANK_IRQ_EN.
module i2c_reg_bank
    import i2c_reg_pkg::*;
#(
    parameter int         NUM_REGS    = 8,
    parameter int         SYNC_STAGES = 2,
    parameter int         FIFO_DEPTH  = 4,
    parameter logic [7:0] ID_VALUE    = ID_DEFAULT
) (
    input  logic               clk,
    input  logic               rst,
    i2c_reg_bank_if.slave      bus,
    input  logic [7:0]         status_in,
    output logic [7:0]         ctrl_out,
    output logic               cmd_valid,
    output logic [7:0]         cmd_data,
    input  logic               cmd_ready,
    output logic               irq
);

    localparam int NUM_SCR = NUM_REGS - int'(ADDR_SCRATCH0);
    localparam int CW      = $clog2(FIFO_DEPTH) + 1;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q, pulse_q;
    logic [7:0]             ctrl_q, ctrl_d;
    logic [7:0]             scratch_q [NUM_SCR];
    logic [7:0]             scratch_d [NUM_SCR];
    logic                   ovf_q, ovf_d;
    logic [7:0]             rdata_q, rdata_d;
    logic [7:0]             flags;
    logic                   wr_cmd, fifo_full, fifo_empty, ovf_pulse;
    logic [CW-1:0]          fifo_count;

    // Sync and edge flops reset high so a strobe already asserted at release is ignored
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q  <= '1;
            prev_q  <= 1'b1;
            pulse_q <= 1'b0;
        end else begin
            sync_q  <= {sync_q[SYNC_STAGES-2:0], bus.i2c_wr};
            prev_q  <= sync_q[SYNC_STAGES-1];
            pulse_q <= sync_q[SYNC_STAGES-1] & ~prev_q;
        end
    end

    assign wr_cmd = pulse_q && (bus.i2c_addr == ADDR_CMD);

    cmd_fifo #(.DEPTH(FIFO_DEPTH), .W(8)) u_fifo (
        .clk            (clk),
        .rst            (rst),
        .push           (wr_cmd),
        .din            (bus.i2c_wdata),
        .pop            (cmd_ready),
        .dout           (cmd_data),
        .full           (fifo_full),
        .empty          (fifo_empty),
        .count          (fifo_count),
        .overflow_pulse (ovf_pulse)
    );

    assign cmd_valid = ~fifo_empty;

`ifdef I2C_REG_BANK_IRQ_EN
    logic irq_q, irq_d;
    assign irq_d = ctrl_q[7] & (cmd_valid | ovf_q);
    always_ff @(posedge clk) begin
        if (rst) irq_q <= 1'b0;
        else     irq_q <= irq_d;
    end
    assign irq = irq_q;
`else
    assign irq = 1'b0;
`endif

    always_comb begin
        ctrl_d    = ctrl_q;
        scratch_d = scratch_q;
        ovf_d     = ovf_q;
        if (pulse_q && bus.i2c_addr == ADDR_CTRL) ctrl_d = bus.i2c_wdata;
        for (int i = 0; i < NUM_SCR; i++) begin
            if (pulse_q && bus.i2c_addr == 8'(int'(ADDR_SCRATCH0) + i))
                scratch_d[i] = bus.i2c_wdata;
        end
        if (pulse_q && bus.i2c_addr == ADDR_FLAGS && bus.i2c_wdata[FLAG_OVF]) ovf_d = 1'b0;
        // A new overflow in the same cycle as a clear must stay visible
        if (ovf_pulse) ovf_d = 1'b1;

        flags             = 8'h00;
        flags[FLAG_OVF]   = ovf_q;
        flags[FLAG_EMPTY] = fifo_empty;
        flags[FLAG_FULL]  = fifo_full;
        flags[FLAG_IRQ]   = irq;

        rdata_d = 8'h00;
        case (bus.i2c_addr)
            ADDR_ID:     rdata_d = ID_VALUE;
            ADDR_CTRL:   rdata_d = ctrl_q;
            ADDR_STATUS: rdata_d = status_in;
            ADDR_CMD:    rdata_d = 8'(fifo_count);
            ADDR_FLAGS:  rdata_d = flags;
            default: begin
                for (int i = 0; i < NUM_SCR; i++) begin
                    if (bus.i2c_addr == 8'(int'(ADDR_SCRATCH0) + i)) rdata_d = scratch_q[i];
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ctrl_q  <= 8'h00;
            ovf_q   <= 1'b0;
            rdata_q <= 8'h00;
            for (int i = 0; i < NUM_SCR; i++) scratch_q[i] <= 8'h00;
        end else begin
            ctrl_q    <= ctrl_d;
            ovf_q     <= ovf_d;
            rdata_q   <= rdata_d;
            scratch_q <= scratch_d;
        end
    end

    assign ctrl_out      = ctrl_q;
    assign bus.i2c_rdata = rdata_q;

endmodule

// File: tb/tb_i2c_reg_bank.sv
// Bench for i2c_reg_bank: register-map table, write-latency, FIFO boundary,
// reset and interrupt sequences with a scoreboard on the command FIFO output.
module tb_i2c_reg_bank;
    localparam int S = 2;
`ifdef I2C_REG_BANK_IRQ_EN
    localparam logic IRQ_ON = 1'b1;
`else
    localparam logic IRQ_ON = 1'b0;
`endif

    typedef struct {
        bit         wr;
        logic [7:0] addr;
        logic [7:0] wdata;
        logic [7:0] exp;
    } rec_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] status_in, ctrl_out, cmd_data;
    logic       cmd_valid, cmd_ready, irq;
    int         checks = 0;
    int         failures = 0;
    logic [7:0] sb [$];
    logic [7:0] mon_exp;
    rec_t       tbl [$];
    int         n_rst;

    i2c_reg_bank_if bus ();

    i2c_reg_bank #(.NUM_REGS(8), .SYNC_STAGES(S), .FIFO_DEPTH(4), .ID_VALUE(8'hA5)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .status_in (status_in),
        .ctrl_out  (ctrl_out),
        .cmd_valid (cmd_valid),
        .cmd_data  (cmd_data),
        .cmd_ready (cmd_ready),
        .irq       (irq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && cmd_valid && cmd_ready) begin
            if (sb.size() == 0) begin
                chk("pop_unexpected", {24'h0, cmd_data}, 32'hFFFF_FFFF);
            end else begin
                mon_exp = sb.pop_front();
                chk("pop_data", {24'h0, cmd_data}, {24'h0, mon_exp});
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic strobe_to_push(input logic [7:0] a, input logic [7:0] d);
        @(posedge clk); #1;
        bus.i2c_addr  = a;
        bus.i2c_wdata = d;
        bus.i2c_wr    = 1'b1;
        repeat (S + 1) @(posedge clk);
        #1;
        bus.i2c_wr = 1'b0;
    endtask

    task automatic do_write(input logic [7:0] a, input logic [7:0] d);
        strobe_to_push(a, d);
        idle(S + 2);
    endtask

    task automatic rd(input logic [7:0] a, input logic [7:0] exp);
        @(posedge clk); #1;
        bus.i2c_addr = a;
        @(posedge clk);
        @(negedge clk);
        chk($sformatf("read_%02h", a), {24'h0, bus.i2c_rdata}, {24'h0, exp});
    endtask

    task automatic drain();
        bit done = 0;
        @(posedge clk); #1;
        cmd_ready = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (!cmd_valid) begin
                done = 1;
                break;
            end
        end
        cmd_ready = 1'b0;
        chk("drain_done", {31'h0, done}, 32'h1);
        chk("sb_empty", 32'(sb.size()), 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl.push_back('{0, 8'h00, 8'h00, 8'hA5});
        tbl.push_back('{0, 8'h01, 8'h00, 8'h00});
        tbl.push_back('{0, 8'h02, 8'h00, 8'h5A});
        tbl.push_back('{0, 8'h03, 8'h00, 8'h00});
        tbl.push_back('{0, 8'h04, 8'h00, 8'h02});
        tbl.push_back('{0, 8'h05, 8'h00, 8'h00});
        tbl.push_back('{0, 8'h07, 8'h00, 8'h00});
        tbl.push_back('{0, 8'h08, 8'h00, 8'h00});
        tbl.push_back('{0, 8'hFF, 8'h00, 8'h00});
        n_rst = tbl.size();
        tbl.push_back('{1, 8'h05, 8'h11, 8'h11});
        tbl.push_back('{1, 8'h07, 8'hEE, 8'hEE});
        tbl.push_back('{1, 8'h06, 8'h5C, 8'h5C});
        tbl.push_back('{1, 8'h00, 8'h12, 8'hA5});
        tbl.push_back('{1, 8'h02, 8'h33, 8'h5A});
        tbl.push_back('{1, 8'h09, 8'h77, 8'h00});
        tbl.push_back('{1, 8'h08, 8'h99, 8'h00});
        tbl.push_back('{1, 8'h01, 8'h42, 8'h42});
        tbl.push_back('{0, 8'h05, 8'h00, 8'h11});

        rst = 1'b1;
        bus.i2c_wr = 1'b0;
        bus.i2c_addr = 8'h00;
        bus.i2c_wdata = 8'h00;
        cmd_ready = 1'b0;
        status_in = 8'h5A;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ctrl", {24'h0, ctrl_out}, 32'h0);
        chk("rst_valid", {31'h0, cmd_valid}, 32'h0);
        chk("rst_data", {24'h0, cmd_data}, 32'h0);
        chk("rst_irq", {31'h0, irq}, 32'h0);
        chk("rst_rdata", {24'h0, bus.i2c_rdata}, 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;

        for (int i = 0; i < n_rst; i++) rd(tbl[i].addr, tbl[i].exp);

        // CTRL write latency: edge k=0 is the first to sample the strobe high
        @(posedge clk); #1;
        bus.i2c_addr = 8'h01;
        bus.i2c_wdata = 8'h3C;
        bus.i2c_wr = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk); #1;
            chk($sformatf("ctrl_lat_k%0d", k), {24'h0, ctrl_out}, (k >= S + 1) ? 32'h3C : 32'h00);
            if (k == 3) bus.i2c_wr = 1'b0;
        end
        idle(S + 2);

        for (int i = n_rst; i < tbl.size(); i++) begin
            if (tbl[i].wr) do_write(tbl[i].addr, tbl[i].wdata);
            rd(tbl[i].addr, tbl[i].exp);
        end

        // Fill past capacity with the consumer stalled
        for (int v = 8'h10; v <= 8'h14; v++) begin
            do_write(8'h03, 8'(v));
            if (v < 8'h14) sb.push_back(8'(v));
        end
        @(negedge clk);
        chk("full_valid", {31'h0, cmd_valid}, 32'h1);
        chk("full_head", {24'h0, cmd_data}, 32'h10);
        rd(8'h03, 8'h04);
        rd(8'h04, 8'h05);
        do_write(8'h04, 8'h01);
        rd(8'h04, 8'h04);

        // Push and pop on the same edge while full
        strobe_to_push(8'h03, 8'h20);
        cmd_ready = 1'b1;
        sb.push_back(8'h20);
        @(posedge clk); #1;
        cmd_ready = 1'b0;
        idle(S + 2);
        rd(8'h04, 8'h04);
        rd(8'h03, 8'h04);
        drain();
        rd(8'h04, 8'h02);

        // Long strobe yields exactly one push
        @(posedge clk); #1;
        bus.i2c_addr = 8'h03;
        bus.i2c_wdata = 8'h55;
        bus.i2c_wr = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        bus.i2c_wr = 1'b0;
        idle(S + 2);
        sb.push_back(8'h55);
        rd(8'h03, 8'h01);
        drain();

        // Reset with a pending entry and a strobe held across release
        do_write(8'h03, 8'h66);
        @(negedge clk);
        chk("pend_valid", {31'h0, cmd_valid}, 32'h1);
        @(posedge clk); #1;
        bus.i2c_addr = 8'h01;
        bus.i2c_wdata = 8'hFF;
        bus.i2c_wr = 1'b1;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        bus.i2c_wr = 1'b0;
        idle(S + 2);
        chk("rstwr_ctrl", {24'h0, ctrl_out}, 32'h0);
        chk("rstwr_valid", {31'h0, cmd_valid}, 32'h0);
        rd(8'h01, 8'h00);
        rd(8'h03, 8'h00);
        rd(8'h04, 8'h02);

        // Interrupt follows cmd_valid one cycle late when enabled
        do_write(8'h01, 8'h80);
        chk("irq_ctrl", {24'h0, ctrl_out}, 32'h80);
        strobe_to_push(8'h03, 8'h77);
        sb.push_back(8'h77);
        @(posedge clk); #1;
        chk("irq_push_valid", {31'h0, cmd_valid}, 32'h1);
        chk("irq_push_same", {31'h0, irq}, 32'h0);
        @(posedge clk); #1;
        chk("irq_push_next", {31'h0, irq}, {31'h0, IRQ_ON});
        rd(8'h04, IRQ_ON ? 8'h80 : 8'h00);
        @(posedge clk); #1;
        cmd_ready = 1'b1;
        @(posedge clk); #1;
        cmd_ready = 1'b0;
        chk("irq_pop_valid", {31'h0, cmd_valid}, 32'h0);
        chk("irq_pop_same", {31'h0, irq}, {31'h0, IRQ_ON});
        @(posedge clk); #1;
        chk("irq_pop_next", {31'h0, irq}, 32'h0);
        chk("final_sb_empty", 32'(sb.size()), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/i2c_reg_bank.md
Name: i2c_reg_bank

Overview:
- Register bank directly downstream of the SCL-clocked i2c_slave.
- Consumes its write strobe, address and write data, and synchronises write events into the `clk` domain.
- Maintains the controller's configuration, status and scratch registers, and returns readback data to the slave's reg_data_in.
- Slide/key commands written over I2C are queued in a small FIFO and handed to the controller core through a valid/ready handshake.

Parameters:
- NUM_REGS, 8, number of decoded addresses (0..NUM_REGS-1).
- SYNC_STAGES, 2, flops in the i2c_wr synchroniser (minimum 2).
- FIFO_DEPTH, 4, command FIFO entries (power of 2, ≥2).
- ID_VALUE, 8'hA5, constant returned at address 0x00.

Ports:
- clk  in  1  system clock; the block's only clock.
- rst  in  1  reset, synchronous, active-high.
- i2c_wr  in  1  write strobe from i2c_slave (SCL domain, asynchronous to `clk`).
- i2c_addr  in  8  register address from i2c_slave; quasi-static.
- i2c_wdata  in  8  write data from i2c_slave; quasi-static.
- i2c_rdata  out  8  readback data to i2c_slave reg_data_in.
- status_in  in  8  live status from the core; read-only at 0x02.
- ctrl_out  out  8  CTRL register contents.
- cmd_valid  out  1  command FIFO not empty.
- cmd_data  out  8  head of command FIFO (first-word fall-through).
- cmd_ready  in  1  core accepts the head entry.
- irq  out  1  interrupt; only active with IRQ_EN.

Behaviour:
- Register map:
  - 0x00 ID: read-only, returns ID_VALUE.
  - 0x01 CTRL: read/write.
  - 0x02 STATUS: read-only, returns status_in.
  - 0x03 CMD: a write pushes i2c_wdata into the FIFO; a read returns the FIFO count, zero-extended.
  - 0x04 FLAGS:
    - bit0 overflow: sticky, write-1-to-clear.
    - bit1 empty and bit2 full: read-only.
    - other bits read 0.
  - 0x05..NUM_REGS-1 SCRATCH: read/write.
  - Addresses ≥ NUM_REGS: writes ignored, reads return 0x00.
- Write detection:
  - i2c_wr passes through SYNC_STAGES flops, then an edge-detect flop.
  - wr_pulse is one `clk` cycle on a synchronised 0→1 edge.
  - A strobe held high produces exactly one write.
  - On wr_pulse, i2c_addr and i2c_wdata are sampled directly.
  - Source contract: i2c_addr/i2c_wdata stable from before i2c_wr rises until it falls; i2c_wr high ≥ SYNC_STAGES+1 `clk` cycles and low ≥ SYNC_STAGES+1 cycles between strobes.
- Write latency: the target register (or FIFO push) updates at the edge SYNC_STAGES+1 cycles after the first `clk` edge that samples i2c_wr high.
- Readback: i2c_rdata is registered every cycle from the current i2c_addr decode, so it reflects a write one cycle after the register changes.
- FIFO:
  - push = wr_pulse & addr==0x03.
  - pop = cmd_valid & cmd_ready.
  - cmd_valid = !empty.
  - cmd_data is stable while cmd_valid & !cmd_ready.
- FIFO boundaries:
  - Push when full with no pop: data dropped, overflow set, count unchanged.
  - Push and pop in the same cycle when full: both take effect, no overflow, count unchanged.
  - Pop when empty is impossible (cmd_valid low).
  - Read and write pointers wrap modulo FIFO_DEPTH; count ranges 0..FIFO_DEPTH.
- Overflow flag:
  - Clear on write 0x04 with bit0=1.
  - If a clear and a new overflow occur in the same cycle, the set wins.
- Reset:
  - Synchronous; all synchroniser and edge flops reset to 1, so a strobe already high at reset release is not a write.
  - CTRL, SCRATCH, FIFO pointers/count and overflow reset to 0.
  - i2c_rdata, ctrl_out, cmd_data, cmd_valid and irq reset to 0.
  - Reset mid-write or mid-handshake discards the write/pending entries; no pulse is emitted after reset.

Optional Feature:
- Macro: I2C_REG_BANK_IRQ_EN.
- With the macro:
  - irq = CTRL[7] & (cmd_valid | overflow), registered, so 1 cycle latency.
  - FLAGS bit7 reads the irq level.
- Without the macro: irq tied 0, FLAGS bit7 reads 0, CTRL[7] is a plain storage bit.

Decomposition:
- Package i2c_reg_pkg holds:
  - address constants ADDR_ID/CTRL/STATUS/CMD/FLAGS/SCRATCH0;
  - FLAGS bit indices (OVF, EMPTY, FULL, IRQ);
  - the default ID value.
- One sub-module: cmd_fifo, a synchronous FWFT FIFO with push/pop/full/empty/count/overflow_pulse.
- The synchroniser stays inline.

Test Plan:
- Reset, then read 0x00 → i2c_rdata=0xA5; read 0x01/0x04 → 0x00 and 0x02 respectively (empty=1).
- Write 0x01=0x3C with a 4-cycle strobe → ctrl_out=0x3C exactly SYNC_STAGES+1 cycles after the strobe is sampled high; one write only.
- Five CMD writes of 0x10..0x14 with cmd_ready=0 → count=4, full=1, overflow=1, cmd_data=0x10; then drive cmd_ready=1 → pops 0x10,0x11,0x12,0x13 in order, after which cmd_valid drops.
- FIFO full with cmd_ready=1 and a CMD push on the same cycle → no overflow, count stays 4, new entry appears last.
- i2c_wr held high across a reset deassertion → no register change; write FLAGS=0x01 → overflow clears; write to 0x09 → no effect, reads 0x00.
- IRQ_EN: CTRL=0x80, push a command → irq=1 the next cycle; pop it → irq=0 the next cycle.
